// File: rtl/led_trail_pwm.sv
// Per-channel LED afterglow: a lit lamp loads full brightness, then fades in
// DECAY_STEP steps and drives a PWM output. Define LED_TRAIL_GAMMA_EN for a squared duty curve.
module led_trail_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 65536,
    parameter int DECAY_STEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] led_in,
    output logic [15:0] led_out,
    output logic        trail_busy
);

    localparam int DW = $clog2(DECAY_DIV);
    localparam logic [PWM_BITS-1:0] MAX        = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);
    localparam logic [DW-1:0]       DECAY_LAST = DW'(DECAY_DIV - 1);

    logic [15:0]                led_q;
    logic [15:0][PWM_BITS-1:0]  bright;
    logic [15:0][PWM_BITS-1:0]  bright_nxt;
    logic [15:0][PWM_BITS-1:0]  duty;
    logic [PWM_BITS-1:0]        pwm_cnt;
    logic [DW-1:0]              decay_cnt;
    logic                       tick;

    function automatic logic [PWM_BITS-1:0] to_duty(input logic [PWM_BITS-1:0] b);
`ifdef LED_TRAIL_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
        // Full scale is pinned so a freshly lit lamp is solidly on, not 254/255.
        return (b == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
        return b;
`endif
    endfunction

    assign tick = (decay_cnt == DECAY_LAST);

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        bright_nxt = bright;
        duty       = '0;
        for (int i = 0; i < 16; i++) begin
            duty[i] = to_duty(bright[i]);
            if (led_q[i]) begin
                bright_nxt[i] = MAX;
            end else if (tick) begin
                bright_nxt[i] = (bright[i] >= STEP) ? bright[i] - STEP : '0;
            end
        end
    end

    // NOTE: the brightness array is ordinary flops, so it is cleared by reset like any other state;
    // state uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            bright     <= '0;
            pwm_cnt    <= '0;
            decay_cnt  <= '0;
            led_out    <= '0;
            trail_busy <= 1'b0;
        end else begin
            led_q      <= led_in;
            bright     <= bright_nxt;
            pwm_cnt    <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            decay_cnt  <= tick ? '0 : decay_cnt + 1'b1;
            trail_busy <= |bright;
            for (int i = 0; i < 16; i++) begin
                led_out[i] <= (pwm_cnt < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm: a cycle-count based reference model queues the
// expected outputs of every edge and a monitor compares them on the falling edge.
module tb_led_trail_pwm;

    localparam int PW    = 8;
    localparam int DIV   = 4;
    localparam int STEPV = 64;
    localparam int MAXV  = (1 << PW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] led_in = 16'h0;
    logic [15:0] led_out;
    logic        trail_busy;

    typedef struct packed {
        logic [15:0] out;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    led_trail_pwm #(.PWM_BITS(PW), .DECAY_DIV(DIV), .DECAY_STEP(STEPV)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .led_out    (led_out),
        .trail_busy (trail_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_duty(input int b);
`ifdef LED_TRAIL_GAMMA_EN
        if (b == MAXV) return MAXV;
        return (b * b) / (1 << PW);
`else
        return b;
`endif
    endfunction

    // Reference: n counts edges since reset release; PWM phase and decay ticks follow from n.
    initial begin
        int          n;
        int          b [16];
        logic [15:0] q;
        exp_t        e;
        n = 0;
        q = '0;
        foreach (b[i]) b[i] = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                n = 0;
                q = '0;
                foreach (b[i]) b[i] = 0;
            end else begin
                n++;
                e = '0;
                for (int i = 0; i < 16; i++) begin
                    e.out[i] = (((n - 1) % MAXV) < model_duty(b[i]));
                    if (b[i] != 0) e.busy = 1'b1;
                end
                for (int i = 0; i < 16; i++) begin
                    if (q[i]) b[i] = MAXV;
                    else if (((n - 1) % DIV) == DIV - 1) b[i] = (b[i] >= STEPV) ? b[i] - STEPV : 0;
                end
                q = led_in;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                check("reset_led_out", 32'(led_out), 32'h0);
                check("reset_trail_busy", 32'(trail_busy), 32'h0);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("led_out", 32'(led_out), 32'(e.out));
                check("trail_busy", 32'(trail_busy), 32'(e.busy));
            end
        end
    end

    task automatic step(input logic [15:0] v);
        @(negedge clk);
        #1 led_in = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        led_in = 16'hFFFF;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        repeat (20) step(16'hFFFF);
        repeat (40) step(16'h0000);
        step(16'h0001);
        repeat (30) step(16'h0000);
        // Reasserts at every phase of the decay tick, including on a tick while bright is 63.
        for (int k = 0; k < 12; k++) begin
            step(16'h0001);
            repeat (k + 8) step(16'h0000);
        end
        for (int r = 0; r < 16; r++) begin
            repeat (8) step(16'(1 << r));
            if (r == 10) begin
                @(posedge clk);
                #1 rst = 1'b0;
                repeat (3) @(negedge clk);
                #1 rst = 1'b1;
            end
        end
        repeat (40) step(16'h0000);
        repeat (400) step(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000);
        repeat (300) step(16'h0000);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 SHALL provide parameter PWM_BITS, default 8, brightness and PWM counter width (4..12).
REQ-002 SHALL provide parameter DECAY_DIV, default 65536, clock cycles per decay tick (>=2).
REQ-003 SHALL provide parameter DECAY_STEP, default 16, brightness units subtracted per decay tick (1..2^PWM_BITS-1).
REQ-004 SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 SHALL provide port led_in  input  16  lamp pattern from the rotating lamp stage, same clock domain.
REQ-007 SHALL provide port led_out  output  16  PWM-dimmed drive to the board LEDs, registered.
REQ-008 SHALL provide port trail_busy  output  1  registered; 1 when any channel brightness is nonzero.

Function
REQ-009 SHALL register led_in into led_q every cycle (1-cycle input latency).
REQ-010 SHALL hold one PWM_BITS-wide brightness register per channel, bright[i]; MAX = 2^PWM_BITS-1.
REQ-011 SHALL run a free-running pwm_cnt counting 0..MAX-1, then wrapping to 0, for a period of MAX cycles.
REQ-012 SHALL run decay_cnt counting 0..DECAY_DIV-1, then wrapping; tick = (decay_cnt == DECAY_DIV-1).
REQ-013 SHALL set bright[i] to MAX on any cycle where led_q[i]==1, regardless of tick (load beats decay).
REQ-014 SHALL, on tick with led_q[i]==0, set bright[i] to bright[i]-DECAY_STEP if bright[i]>=DECAY_STEP, else 0 (saturate at 0, no wrap).
REQ-015 SHALL otherwise hold bright[i].
REQ-016 SHALL register led_out[i] <= (pwm_cnt < duty[i]), where duty[i] is derived from the current bright[i] (REQ-027/028).
REQ-017 SHALL give duty MAX = always on (led_out 1 every cycle) and duty 0 = always off.
REQ-018 SHALL give a latency of 3 edges from led_in[i] rising to led_out[i]=1: sample, load, output.
REQ-019 SHALL register trail_busy <= OR of all bright[i] != 0.
REQ-020 SHALL treat channels independently; multiple or zero bits set in led_in are legal.
REQ-021 SHALL make a lit channel decay only after led_in[i] falls; the first decrement occurs on the next tick after led_q[i]==0.

Reset
REQ-022 SHALL, while rst==0, asynchronously clear led_q, all bright[i], pwm_cnt, decay_cnt, led_out and trail_busy to 0.
REQ-023 SHALL discard all trail state on reset asserted mid-fade; no partial-brightness memory survives.
REQ-024 SHALL resume counting from 0 on the first rising clk after rst deasserts, with led_out 0 on that edge.

Configuration
REQ-025 SHALL use macro LED_TRAIL_GAMMA_EN to select the brightness-to-duty mapping.
REQ-026 SHALL have no parameter or port differences between the two builds.
REQ-027 SHALL, without LED_TRAIL_GAMMA_EN, use duty[i] = bright[i] (linear).
REQ-028 SHALL, with LED_TRAIL_GAMMA_EN, use duty[i] = MAX if bright[i]==MAX, else (bright[i]*bright[i]) >> PWM_BITS. The product is 2*PWM_BITS wide, with no overflow.

Verification (PWM_BITS=8, DECAY_DIV=4, DECAY_STEP=64 unless noted)
REQ-029 SHALL check reset: hold rst=0 with led_in=16'hFFFF for 10 cycles -> led_out=0 and trail_busy=0. Release -> led_out=16'hFFFF from the 3rd edge.
REQ-030 SHALL check load latency: led_in=16'h0001 at edge k -> bright[0]=255 after edge k+1, led_out[0]=1 from edge k+2, trail_busy=1.
REQ-031 SHALL check decay and saturation: drop led_in to 0 -> bright[0] steps 255,191,127,63,0 on successive ticks, then stays 0. trail_busy returns to 0 one edge after bright reaches 0.
REQ-032 SHALL check duty: bright=127 (linear build) -> led_out[0] high for exactly 127 of every 255 cycles. With LED_TRAIL_GAMMA_EN, bright=127 -> high for 63 of every 255 cycles.
REQ-033 SHALL check the simultaneous load/tick event: led_in[0] reasserts on a tick cycle while bright[0]=63 -> bright[0]=255, not 0.
REQ-034 SHALL check rotation: drive the one-hot led_in pattern 1,2,4..8000 every 8 cycles -> trailing channels hold distinct decreasing brightness. Assert reset mid-pattern -> everything returns to 0 asynchronously.
